state_recorder: RTL and testbench

STATE_RECORDER -- requirements
Module: state_recorder

---
 rtl/st_rec_pkg.sv | 31 +++
 rtl/st_rec_ram.sv | 25 ++
 rtl/state_recorder.sv | 196 +++++++++++++++++++
 tb/tb_state_recorder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/st_rec_pkg.sv
// Shared constants and types for the state recorder: buffer map offsets, depth,
// wipe/readout state encodings and the palette mirror fold.
package st_rec_pkg;

    localparam int BUF_DEPTH = 512;
    localparam int BUF_AW    = 9;

    localparam logic [BUF_AW-1:0] PPU_BASE = 9'h000;
    localparam logic [BUF_AW-1:0] APU_BASE = 9'h008;
    localparam logic [BUF_AW-1:0] PAL_BASE = 9'h020;
    localparam logic [BUF_AW-1:0] MAP_BASE = 9'h040;
    localparam logic [BUF_AW-1:0] CNT_LO   = 9'h044;
    localparam logic [BUF_AW-1:0] CNT_HI   = 9'h045;
    localparam logic [BUF_AW-1:0] FLAGS    = 9'h046;

    typedef enum logic {
        WIPE_IDLE,
        WIPE_RUN
    } wipe_state_e;

    typedef enum logic {
        SRC_RAM,
        SRC_LIVE
    } read_src_e;

    // Sprite palette entries 0x10/0x14/0x18/0x1C alias the background entries.
    function automatic logic [4:0] palFold(input logic [4:0] idx);
        palFold = (idx[4] && (idx[1:0] == 2'b00)) ? {1'b0, idx[3:0]} : idx;
    endfunction

endpackage

// File: rtl/st_rec_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port
// returning the old contents on a same-address collision.
module st_rec_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/state_recorder.sv
// Records the last CPU writes to PPU, APU/IO and mapper registers plus the
// palette shadow into a 512-byte buffer, with a wipe sweep and registered readout.
module state_recorder
    import st_rec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_strobe,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_rw,
    input  logic        freeze,
    input  logic        clear,
    output logic        busy,
    input  logic [8:0]  st_rec_addr,
    output logic [7:0]  st_rec_data
);

    wipe_state_e       wipeState_q, wipeState_d;
    logic [BUF_AW-1:0] wipePtr_q, wipePtr_d;
    logic [13:0]       v_q, v_d;
    logic              w_q, w_d;
    logic              ctrlInc_q, ctrlInc_d;
    logic [15:0]       cnt_q, cnt_d;
    read_src_e         srcSel_q, srcSel_d;
    logic [7:0]        liveData_q, liveData_d;

    logic              isPpu, isApu, isMap;
    logic [2:0]        ppuReg;
    logic              wrStrobe, rdStrobe, capture;
    logic [13:0]       vInc;
    logic              capWe;
    logic [BUF_AW-1:0] capAddr;
    logic              ramWe;
    logic [BUF_AW-1:0] ramWaddr;
    logic [7:0]        ramWdata;
    logic [7:0]        ramRdata;

    assign busy     = (wipeState_q == WIPE_RUN);
    assign isPpu    = (cpu_addr[15:13] == 3'b001);
    assign isApu    = (cpu_addr >= 16'h4000) && (cpu_addr <= 16'h4017);
    assign isMap    = cpu_addr[15];
    assign ppuReg   = cpu_addr[2:0];
    assign wrStrobe = cpu_strobe && !cpu_rw;
    assign rdStrobe = cpu_strobe && cpu_rw;
    assign capture  = wrStrobe && !freeze && !busy;
    assign vInc     = ctrlInc_q ? 14'd32 : 14'd1;

    // PPU address/toggle tracking follows the bus regardless of freeze or wipe.
    always_comb begin
        v_d       = v_q;
        w_d       = w_q;
        ctrlInc_d = ctrlInc_q;
        if (isPpu && wrStrobe) begin
            case (ppuReg)
                3'd0: ctrlInc_d = cpu_data_in[2];
                3'd5: w_d = !w_q;
                3'd6: begin
                    w_d = !w_q;
                    if (w_q) begin
                        v_d[7:0] = cpu_data_in;
                    end else begin
                        v_d[13:8] = cpu_data_in[5:0];
                    end
                end
                3'd7: v_d = v_q + vInc;
                default: ;
            endcase
        end else if (isPpu && rdStrobe) begin
            if (ppuReg == 3'd2) begin
                w_d = 1'b0;
            end else if (ppuReg == 3'd7) begin
                v_d = v_q + vInc;
            end
        end
    end

    // Buffer slot for a captured write; $2007 only lands when v points at palette.
    always_comb begin
        capWe   = 1'b0;
        capAddr = '0;
        if (capture) begin
            if (isPpu) begin
                if (ppuReg != 3'd7) begin
                    capWe   = 1'b1;
                    capAddr = PPU_BASE + {6'd0, ppuReg};
                end else if (v_q[13:8] == 6'h3F) begin
                    capWe   = 1'b1;
                    capAddr = PAL_BASE + {4'd0, palFold(v_q[4:0])};
                end
            end else if (isApu) begin
                capWe   = 1'b1;
                capAddr = APU_BASE + {4'd0, cpu_addr[4:0]};
            end else if (isMap) begin
                capWe   = 1'b1;
                capAddr = MAP_BASE + {7'd0, cpu_addr[14:13]};
            end
        end
    end

    // Wipe sweep: a clear in any state (re)starts from address 0.
    always_comb begin
        wipeState_d = wipeState_q;
        wipePtr_d   = wipePtr_q;
        case (wipeState_q)
            WIPE_IDLE: begin
                if (clear) begin
                    wipeState_d = WIPE_RUN;
                    wipePtr_d   = '0;
                end
            end
            WIPE_RUN: begin
                if (clear) begin
                    wipePtr_d = '0;
                end else if (wipePtr_q == BUF_AW'(BUF_DEPTH - 1)) begin
                    wipeState_d = WIPE_IDLE;
                end else begin
                    wipePtr_d = wipePtr_q + 1'b1;
                end
            end
            default: wipeState_d = WIPE_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (capWe) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter and flags bypass the RAM; their snapshot is aligned with the RAM read.
    always_comb begin
        srcSel_d   = SRC_RAM;
        liveData_d = 8'h00;
        case (st_rec_addr)
            CNT_LO: begin
                srcSel_d   = SRC_LIVE;
                liveData_d = cnt_q[7:0];
            end
            CNT_HI: begin
                srcSel_d   = SRC_LIVE;
                liveData_d = cnt_q[15:8];
            end
            FLAGS: begin
                srcSel_d   = SRC_LIVE;
                liveData_d = {5'd0, busy, freeze, w_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wipeState_q <= WIPE_IDLE;
            wipePtr_q   <= '0;
            v_q         <= '0;
            w_q         <= 1'b0;
            ctrlInc_q   <= 1'b0;
            cnt_q       <= '0;
            srcSel_q    <= SRC_LIVE;
            liveData_q  <= 8'h00;
        end else begin
            wipeState_q <= wipeState_d;
            wipePtr_q   <= wipePtr_d;
            v_q         <= v_d;
            w_q         <= w_d;
            ctrlInc_q   <= ctrlInc_d;
            cnt_q       <= cnt_d;
            srcSel_q    <= srcSel_d;
            liveData_q  <= liveData_d;
        end
    end

    assign ramWe    = !reset && (busy || capWe);
    assign ramWaddr = busy ? wipePtr_q : capAddr;
    assign ramWdata = busy ? 8'h00 : cpu_data_in;

    st_rec_ram #(
        .DEPTH (BUF_DEPTH),
        .ADDR_W(BUF_AW),
        .DATA_W(8)
    ) u_ram (
        .clk    (clk),
        .we_i   (ramWe),
        .waddr_i(ramWaddr),
        .wdata_i(ramWdata),
        .raddr_i(st_rec_addr),
        .rdata_o(ramRdata)
    );

    assign st_rec_data = (srcSel_q == SRC_LIVE) ? liveData_q : ramRdata;

endmodule

// File: tb/tb_state_recorder.sv
// Scoreboard bench for state_recorder: directed bus traffic, readback
// expectations queued at issue time and checked by an independent monitor.
module tb_state_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_strobe;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_rw;
    logic        freeze;
    logic        clear;
    logic        busy;
    logic [8:0]  st_rec_addr;
    logic [7:0]  st_rec_data;

    int          vecCount  = 0;
    int          missCount = 0;
    logic [7:0]  expQ[$];
    string       nameQ[$];
    logic        rdReq     = 1'b0;
    logic        rdPending = 1'b0;
    int          busyCycles;

    state_recorder dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_strobe (cpu_strobe),
        .cpu_addr   (cpu_addr),
        .cpu_data_in(cpu_data_in),
        .cpu_rw     (cpu_rw),
        .freeze     (freeze),
        .clear      (clear),
        .busy       (busy),
        .st_rec_addr(st_rec_addr),
        .st_rec_data(st_rec_data)
    );

    always #5 clk = ~clk;

    // Monitor: a read issued before a rising edge is presented after it.
    always @(posedge clk) rdPending <= rdReq;

    task automatic checkOutput();
        logic [7:0] expVal;
        string      nm;
        vecCount++;
        if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL unexpected_read: got %02h, no expected value queued", st_rec_data);
        end else begin
            expVal = expQ.pop_front();
            nm     = nameQ.pop_front();
            if (st_rec_data !== expVal) begin
                missCount++;
                $display("[TB] FAIL %s: got %02h, expected %02h", nm, st_rec_data, expVal);
            end
        end
    endtask

    always @(negedge clk) if (rdPending) checkOutput();

    task automatic checkValue(input string nm, input logic [15:0] actual, input logic [15:0] expVal);
        vecCount++;
        if (actual !== expVal) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, actual, expVal);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        cpu_strobe  = 1'b1;
        cpu_rw      = rw;
        cpu_addr    = addr;
        cpu_data_in = data;
        @(negedge clk);
        cpu_strobe  = 1'b0;
        cpu_rw      = 1'b1;
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
        applyStimulus(1'b0, addr, data);
    endtask

    task automatic busRead(input logic [15:0] addr);
        applyStimulus(1'b1, addr, 8'h00);
    endtask

    task automatic readBack(input logic [8:0] addr, input logic [7:0] expVal, input string nm);
        @(negedge clk);
        st_rec_addr = addr;
        rdReq       = 1'b1;
        expQ.push_back(expVal);
        nameQ.push_back(nm);
        @(negedge clk);
        rdReq       = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        cpu_strobe  = 1'b0;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
        cpu_rw      = 1'b1;
        freeze      = 1'b0;
        clear       = 1'b0;
        st_rec_addr = 9'h000;
        repeat (3) @(negedge clk);
        checkValue("reset_busy", {15'd0, busy}, 16'h0000);
        checkValue("reset_data", {8'd0, st_rec_data}, 16'h0000);

        // Reset must abort a running wipe.
        @(negedge clk);
        reset = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (5) @(negedge clk);
        checkValue("wipe_started", {15'd0, busy}, 16'h0001);
        reset = 1'b1;
        @(negedge clk);
        checkValue("reset_abort_busy", {15'd0, busy}, 16'h0000);
        checkValue("reset_abort_data", {8'd0, st_rec_data}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Wipe with restart at clk 100 and a dropped write at clk 200.
        @(negedge clk);
        clear = 1'b1;
        busyCycles = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            clear       = (k == 100);
            cpu_strobe  = (k == 200);
            cpu_rw      = (k == 200) ? 1'b0 : 1'b1;
            cpu_addr    = 16'h2001;
            cpu_data_in = 8'h55;
            rdReq       = (k == 50);
            st_rec_addr = 9'h046;
            if (k == 50) begin
                expQ.push_back(8'h04);
                nameQ.push_back("flags_during_wipe");
            end
            if (!busy) break;
            busyCycles++;
        end
        clear      = 1'b0;
        cpu_strobe = 1'b0;
        cpu_rw     = 1'b1;
        rdReq      = 1'b0;
        checkValue("busy_cycles", 16'(busyCycles), 16'd612);

        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            st_rec_addr = 9'(a);
            rdReq       = 1'b1;
            expQ.push_back(8'h00);
            nameQ.push_back($sformatf("wiped_%03h", a));
        end
        @(negedge clk);
        rdReq = 1'b0;

        // Mirror of $2001 overwrites the same slot.
        busWrite(16'h2001, 8'h1E);
        busWrite(16'h3FF9, 8'hA5);
        readBack(9'h001, 8'hA5, "mirror_2001");
        readBack(9'h044, 8'h02, "cnt_lo_2");
        readBack(9'h045, 8'h00, "cnt_hi_2");

        // Palette writes with +1 increment and sprite-entry fold.
        busWrite(16'h2000, 8'h00);
        busWrite(16'h2006, 8'h3F);
        busWrite(16'h2006, 8'h10);
        busWrite(16'h2007, 8'h0F);
        busWrite(16'h2007, 8'h30);
        readBack(9'h020, 8'h0F, "pal_fold_10");
        readBack(9'h031, 8'h30, "pal_11");
        busWrite(16'h2007, 8'hC3);
        readBack(9'h032, 8'hC3, "pal_v_3F12");
        readBack(9'h044, 8'h08, "cnt_lo_8");

        // +32 increment.
        busWrite(16'h2000, 8'h04);
        busWrite(16'h2006, 8'h3F);
        busWrite(16'h2006, 8'h00);
        busWrite(16'h2007, 8'h11);
        readBack(9'h020, 8'h11, "pal_00");
        busWrite(16'h2007, 8'h22);
        readBack(9'h020, 8'h22, "pal_v_3F20");
        readBack(9'h021, 8'h00, "pal_01_untouched");

        // $2002 read resets the write toggle.
        busWrite(16'h2006, 8'h21);
        busRead(16'h2002);
        busWrite(16'h2006, 8'h3F);
        busWrite(16'h2006, 8'h05);
        readBack(9'h046, 8'h00, "flags_w0");
        busWrite(16'h2007, 8'h77);
        readBack(9'h025, 8'h77, "pal_v_3F05");
        readBack(9'h044, 8'h11, "cnt_lo_17");

        // Freeze suppresses capture.
        freeze = 1'b1;
        busWrite(16'h4015, 8'h0F);
        busWrite(16'hA000, 8'h80);
        readBack(9'h046, 8'h02, "flags_freeze");
        readBack(9'h01D, 8'h00, "frozen_4015");
        readBack(9'h041, 8'h00, "frozen_a000");
        readBack(9'h044, 8'h11, "frozen_cnt");
        freeze = 1'b0;
        busWrite(16'hA000, 8'h80);
        readBack(9'h041, 8'h80, "map_a000");

        // Decode boundaries.
        busWrite(16'h4017, 8'h5A);
        busWrite(16'h4018, 8'h11);
        busWrite(16'h6000, 8'h22);
        busWrite(16'hE000, 8'h3C);
        readBack(9'h01F, 8'h5A, "apu_4017");
        readBack(9'h043, 8'h3C, "map_e000");
        readBack(9'h044, 8'h14, "cnt_lo_20");
        readBack(9'h045, 8'h00, "cnt_hi_20");
        readBack(9'h000, 8'h04, "ppu_2000");
        readBack(9'h006, 8'h05, "ppu_2006");
        readBack(9'h007, 8'h00, "ppu_2007_unused");

        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
